// File: rtl/matrix_pkg.sv
// Shared definitions for the tt_um_matrix pin protocol: FSM states, uio bit indices and
// frame sizing.
package matrix_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrStb,
    StWrGap,
    StWaitRdy,
    StRdStb,
    StRdCap,
    StOut
  } state_e;

  localparam int unsigned UIO_WR  = 0;
  localparam int unsigned UIO_RD  = 1;
  localparam int unsigned UIO_RDY = 2;

  // Each N x N result element is 16 bits, sent LSB first.
  function automatic int unsigned out_bytes(input int unsigned n);
    return 2 * n * n;
  endfunction

endpackage

// File: rtl/matrix_pin_host.sv
// Host side of the tt_um_matrix pin protocol: streams operand bytes out with WR strobes,
// waits for RDY, then reads result bytes back with RD strobes onto a valid/ready stream.
module matrix_pin_host
  import matrix_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic [7:0] pin_ui,
  output logic [7:0] pin_uio_out,
  input  logic [7:0] pin_uio_in,
  input  logic [7:0] pin_uo,
  output logic       busy,
  output logic       err
);

  localparam int unsigned ELEMS     = N * N;
  localparam int unsigned IN_BYTES  = 2 * ELEMS;
  localparam int unsigned OUT_BYTES = out_bytes(N);
  localparam int unsigned CW        = $clog2(IN_BYTES + 1);
  localparam int unsigned TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] CntIn      = CW'(IN_BYTES);
  localparam logic [CW-1:0] CntOut     = CW'(OUT_BYTES);
  localparam logic [CW-1:0] CntOutLast = CW'(OUT_BYTES - 1);
  localparam logic [TW-1:0] TLast      = TW'(TIMEOUT - 1);

  state_e        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic          r_s_ready, w_s_ready;
  logic          r_m_valid, w_m_valid;
  logic [7:0]    r_m_data, w_m_data;
  logic          r_m_last, w_m_last;
  logic [7:0]    r_pin_ui, w_pin_ui;
  logic          r_err, w_err;
  logic          w_s_hs;
  logic          w_unused_uio;

  assign w_unused_uio = ^{pin_uio_in[7:3], pin_uio_in[1:0]};
  assign w_s_hs       = s_valid && r_s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_pin_ui  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_tcnt    <= w_tcnt;
      r_s_ready <= w_s_ready;
      r_m_valid <= w_m_valid;
      r_m_data  <= w_m_data;
      r_m_last  <= w_m_last;
      r_pin_ui  <= w_pin_ui;
      r_err     <= w_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_tcnt    = r_tcnt;
    w_m_valid = r_m_valid;
    w_m_data  = r_m_data;
    w_m_last  = r_m_last;
    w_pin_ui  = r_pin_ui;
    w_err     = r_err;

    unique case (r_state)
      StIdle: begin
        if (w_s_hs) begin
          w_pin_ui = s_data;
          w_cnt    = CW'(1);
          w_state  = StWrStb;
        end
      end
      StWrStb: w_state = StWrGap;
      StWrGap: begin
        if (r_cnt == CntIn) begin
          w_tcnt  = '0;
          w_state = StWaitRdy;
        end else if (w_s_hs) begin
          w_pin_ui = s_data;
          w_cnt    = r_cnt + CW'(1);
          w_state  = StWrStb;
        end
      end
      StWaitRdy: begin
        if (pin_uio_in[UIO_RDY]) begin
          w_cnt   = '0;
          w_state = StRdStb;
        end else if (r_tcnt == TLast) begin
          w_err   = 1'b1;
          w_state = StIdle;
        end else begin
          w_tcnt = r_tcnt + TW'(1);
        end
      end
      StRdStb: w_state = StRdCap;
      StRdCap: begin
        w_m_data  = pin_uo;
        w_m_valid = 1'b1;
        w_m_last  = (r_cnt == CntOutLast);
        w_state   = StOut;
      end
      StOut: begin
        // The next RD strobe waits for this handshake, so no result byte is ever overwritten.
        if (m_ready) begin
          w_m_valid = 1'b0;
          w_m_last  = 1'b0;
          w_cnt     = r_cnt + CW'(1);
          w_state   = (w_cnt == CntOut) ? StIdle : StRdStb;
        end
      end
      default: w_state = StIdle;
    endcase

    // Registered so that s_ready reads 0 while rst is held; never open once all bytes are in.
    w_s_ready = (w_state == StIdle) || ((w_state == StWrGap) && (w_cnt != CntIn));
  end

  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign pin_ui      = r_pin_ui;
  assign pin_uio_out = {6'b0, r_state == StRdStb, r_state == StWrStb};
  assign busy        = (r_state != StIdle);
  assign err         = r_err;

endmodule

// File: doc/matrix_pin_host.md
Name: matrix_pin_host

Overview:
- Host-side counterpart of the tt_um_matrix pin protocol, for FPGA demo and loop-back builds.
- Accepts the A and B operand bytes on an upstream valid/ready stream and serialises them onto the design's dedicated input pins with write strobes.
- Waits for the design's ready pin, then pulls result bytes back with read strobes and emits them on a downstream valid/ready stream.
- Times out with a sticky error if ready never arrives.

Parameters:
- N, 2, matrix dimension; A and B are N x N, 8-bit unsigned elements, row-major.
- TIMEOUT, 1024, cycles to wait in WAIT_RDY before declaring an error; minimum 2.
- Derived, not overridable: ELEMS = N*N; IN_BYTES = 2*ELEMS; OUT_BYTES = 2*ELEMS (16-bit results, LSB first).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream operand byte valid.
- s_ready  out  1  upstream operand byte accepted when s_valid && s_ready.
- s_data  in  8  operand byte; A elements first, then B elements.
- m_valid  out  1  result byte valid.
- m_ready  in  1  downstream accepts the result byte.
- m_data  out  8  result byte.
- m_last  out  1  high with the final result byte of a frame.
- pin_ui  out  8  drives the design's ui_in.
- pin_uio_out  out  8  drives the design's uio_in; bit0 = WR strobe, bit1 = RD strobe; all other bits 0.
- pin_uio_in  in  8  design's uio_out; bit2 = RDY.
- pin_uo  in  8  design's uo_out; result byte.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, pin_ui=0, pin_uio_out=0, busy=0, err=0, byte counter=0, timeout counter=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately; no further strobes are issued.
- IDLE:
  - s_ready=1.
  - On handshake, register s_data into pin_ui, go to WR_STB, counter=1.
- WR_STB (1 cycle):
  - pin_uio_out[0]=1 with pin_ui held stable.
  - Next state is WR_GAP.
- WR_GAP (1 cycle):
  - Strobe low; s_ready=1 in this cycle only.
  - If counter==IN_BYTES, go to WAIT_RDY and clear the timeout counter.
  - Else, on handshake, latch the byte, increment the counter and go to WR_STB.
  - Else stay in WR_GAP; s_ready remains high while waiting.
- Write rate: at most 1 byte per 2 cycles; the WR pulse is always exactly 1 cycle wide.
- WAIT_RDY:
  - If pin_uio_in[2]=1, go to RD_STB with counter=0.
  - Else increment the timeout counter.
  - When the timeout counter reaches TIMEOUT-1 without RDY, set err=1 and return to IDLE; no bytes are emitted.
- RD_STB (1 cycle):
  - pin_uio_out[1]=1.
  - Next state is RD_CAP.
- RD_CAP (1 cycle): capture pin_uo into m_data, set m_valid=1, set m_last=(counter==OUT_BYTES-1), go to OUT.
- OUT:
  - Hold m_valid, m_data and m_last stable until m_ready.
  - On handshake, clear m_valid and increment the counter.
  - If the incremented counter equals OUT_BYTES, go to IDLE; else go to RD_STB.
  - m_ready high in the same cycle as m_valid rises is legal.
- Back-pressure: no RD strobe is ever issued while an un-accepted result byte is held.
- WR and RD strobes are never high simultaneously.
- pin_uio_out[7:2] is always 0.
- err does not block new frames.
- Counter width is clog2(IN_BYTES+1); wrap-around is impossible by construction.

Decomposition:
- Shared package matrix_pkg holds:
  - The state enum: IDLE, WR_STB, WR_GAP, WAIT_RDY, RD_STB, RD_CAP, OUT.
  - Pin bit-index constants: UIO_WR=0, UIO_RD=1, UIO_RDY=2.
  - A result-byte-count function.
- These constants are shared with tt_um_matrix.
- No sub-module: one FSM with two counters.

Test Plan:
- Basic multiply:
  - Stimulus: send A=[1,2,3,4], B=[5,6,7,8] as 8 bytes; behavioural responder raises RDY 20 cycles after the 8th WR and returns C.
  - Response: exactly 8 WR pulses carrying 01..08; then 8 RD pulses; m_data = 13,00,16,00,2B,00,32,00 (hex); m_last only on the 8th byte; busy falls the cycle after.
- Upstream gaps: s_valid low 5 cycles between each byte -> WR pulses stay 1 cycle wide; pin_ui is stable during every pulse; byte order preserved.
- Back-pressure: m_ready low for 10 cycles on result byte 3 -> m_data held constant; zero RD pulses during the stall; 8 bytes total, no duplicates.
- Timeout: with TIMEOUT=16, RDY never asserted -> err=1 exactly 16 cycles after entering WAIT_RDY; state IDLE; m_valid never rises; a following good frame completes correctly with err still 1.
- Reset mid-frame: rst asserted after 3 WR pulses -> all outputs return to reset values next cycle; no strobes until the next upstream byte arrives.
- Strobe exclusivity: check on every cycle of all tests that pin_uio_out[1:0] != 2'b11.
